// File: rtl/int_controller.sv
// Platform-level external interrupt controller.
// Level-sensitive sources pass through a per-source IDLE/PENDING/IN_SERVICE
// gateway. The highest-priority pending, enabled source above the threshold
// raises irq_out (MEIP). Software acknowledges it through a memory-mapped
// claim (read) / complete (write) register.
module int_controller #(
  parameter int NUM_SRC = 16,
  parameter int PRIO_W  = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [9:0]         bus_addr,
  input  logic               bus_wena,
  input  logic [31:0]        bus_wdata,
  input  logic               bus_rena,
  output logic [31:0]        bus_rdata,
  output logic               irq_out
);

  localparam int ID_W = 5;

  // Word indices (byte address >> 2) of the fixed registers
  localparam logic [7:0] W_PENDING = 8'h20;  // 0x080
  localparam logic [7:0] W_ENABLE  = 8'h40;  // 0x100
  localparam logic [7:0] W_THRESH  = 8'h80;  // 0x200
  localparam logic [7:0] W_CLAIM   = 8'h81;  // 0x204

  typedef enum logic [1:0] {
    GW_IDLE       = 2'd0,
    GW_PENDING    = 2'd1,
    GW_IN_SERVICE = 2'd2
  } gw_state_t;

  logic [7:0]              word;
  logic [NUM_SRC*PRIO_W-1:0] prio_flat;
  logic [NUM_SRC:0]        enable_reg;
  logic [PRIO_W-1:0]       threshold_reg;
  logic [NUM_SRC:0]        pend_bits;
  logic                    claim_fire;
  logic                    complete_fire;
  logic [ID_W-1:0]         complete_id;
  logic [ID_W-1:0]         max_id;
  logic [PRIO_W-1:0]       max_prio;
  logic [ID_W-1:0]         claim_id;
  logic                    unused_bits;

  assign word          = bus_addr[9:2];
  assign claim_fire    = bus_rena && (word == W_CLAIM);
  assign complete_fire = bus_wena && (word == W_CLAIM);
  assign complete_id   = bus_wdata[ID_W-1:0];
  assign pend_bits[0]  = 1'b0;
  // Byte-offset bits and high write-data bits carry no meaning here
  assign unused_bits   = ^{bus_addr[1:0], bus_wdata};

  // Enable and threshold registers; enable bit 0 (ID "none") stays 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enable_reg    <= '0;
      threshold_reg <= '0;
    end else begin
      if (bus_wena && (word == W_ENABLE))
        enable_reg <= {bus_wdata[NUM_SRC:1], 1'b0};
      if (bus_wena && (word == W_THRESH))
        threshold_reg <= bus_wdata[PRIO_W-1:0];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
      localparam logic [ID_W-1:0] SRC_ID = ID_W'(gi + 1);
      logic [PRIO_W-1:0] prio_reg;
      gw_state_t         state_reg;
      gw_state_t         state_next;

      // Priority register for this source
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          prio_reg <= '0;
        else if (bus_wena && (word == 8'(gi + 1)))
          prio_reg <= bus_wdata[PRIO_W-1:0];
      end

      // Gateway state register
      always_ff @(posedge clk or posedge reset) begin
        if (reset)
          state_reg <= GW_IDLE;
        else
          state_reg <= state_next;
      end

      // Gateway transitions: IN_SERVICE masks the level until completed
      always_comb begin
        state_next = state_reg;
        case (state_reg)
          GW_IDLE:       if (irq_src[gi]) state_next = GW_PENDING;
          GW_PENDING:    if (claim_fire && (claim_id == SRC_ID)) state_next = GW_IN_SERVICE;
          GW_IN_SERVICE: if (complete_fire && (complete_id == SRC_ID)) state_next = GW_IDLE;
          default:       state_next = GW_IDLE;
        endcase
      end

      assign pend_bits[gi+1]                  = (state_reg == GW_PENDING);
      assign prio_flat[gi*PRIO_W +: PRIO_W]   = prio_reg;
    end
  endgenerate

  // Arbiter: strict '>' while scanning upward keeps the lowest ID on ties,
  // and starting from 0 excludes priority-0 sources automatically
  always_comb begin
    max_id   = '0;
    max_prio = '0;
    for (int i = 1; i <= NUM_SRC; i++) begin
      if (pend_bits[i] && enable_reg[i] &&
          (prio_flat[(i-1)*PRIO_W +: PRIO_W] > max_prio)) begin
        max_prio = prio_flat[(i-1)*PRIO_W +: PRIO_W];
        max_id   = ID_W'(i);
      end
    end
    claim_id = (max_prio > threshold_reg) ? max_id : '0;
  end

  // Registered interrupt request toward the CSR file
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      irq_out <= 1'b0;
    else
      irq_out <= (claim_id != '0);
  end

  // Combinational read mux; unmapped words and the ID 0 slot read 0
  always_comb begin
    bus_rdata = '0;
    if (word == W_PENDING)
      bus_rdata = 32'(pend_bits);
    else if (word == W_ENABLE)
      bus_rdata = 32'(enable_reg);
    else if (word == W_THRESH)
      bus_rdata = 32'(threshold_reg);
    else if (word == W_CLAIM)
      bus_rdata = 32'(claim_id);
    else begin
      for (int i = 1; i <= NUM_SRC; i++) begin
        if (word == 8'(i))
          bus_rdata = 32'(prio_flat[(i-1)*PRIO_W +: PRIO_W]);
      end
    end
  end

endmodule

// File: tb/tb_int_controller.sv
// Directed bench for int_controller: register map, gateway, arbitration,
// threshold gating, claim/complete handshake and asynchronous reset.
module tb_int_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] irq_src;
  logic [9:0]  bus_addr;
  logic        bus_wena;
  logic [31:0] bus_wdata;
  logic        bus_rena;
  logic [31:0] bus_rdata;
  logic        irq_out;

  int errors = 0;
  int checks = 0;

  int_controller #(.NUM_SRC(16), .PRIO_W(3)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq_src   (irq_src),
    .bus_addr  (bus_addr),
    .bus_wena  (bus_wena),
    .bus_wdata (bus_wdata),
    .bus_rena  (bus_rena),
    .bus_rdata (bus_rdata),
    .irq_out   (irq_out)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-22s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One-cycle register write, applied at the posedge between two negedges
  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wdata = d; bus_wena = 1'b1;
    @(negedge clk);
    bus_wena = 1'b0;
  endtask

  // One-cycle read strobe (claim side effect lands on the enclosed posedge)
  task automatic rd(input logic [9:0] a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_rena = 1'b1;
    #1 d = bus_rdata;
    @(negedge clk);
    bus_rena = 1'b0;
  endtask

  // Side-effect-free look at a register (no strobe, no clock edge)
  task automatic peek(input logic [9:0] a, output logic [31:0] d);
    bus_addr = a;
    #1 d = bus_rdata;
  endtask

  task automatic edge_wait(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] d;
    reset = 1'b1; irq_src = '0; bus_addr = '0; bus_wena = 1'b0;
    bus_wdata = '0; bus_rena = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state
    check("rst_irq_out", {31'd0, irq_out}, 32'd0);
    peek(10'h080, d); check("rst_pending", d, 32'h0);
    peek(10'h100, d); check("rst_enable", d, 32'h0);
    peek(10'h00C, d); check("rst_prio3", d, 32'h0);

    // 1: single source latency and claim
    wr(10'h00C, 32'd2);
    wr(10'h100, 32'h0000_0008);
    @(negedge clk); irq_src[2] = 1'b1;
    edge_wait(1); check("t1_irq_edge1", {31'd0, irq_out}, 32'd0);
    edge_wait(1); check("t1_irq_edge2", {31'd0, irq_out}, 32'd1);
    rd(10'h204, d); check("t1_claim", d, 32'd3);
    edge_wait(1); check("t1_irq_after", {31'd0, irq_out}, 32'd0);
    @(negedge clk); irq_src[2] = 1'b0;
    wr(10'h204, 32'd3);

    // 2: tie broken by lowest ID, then higher priority wins
    wr(10'h008, 32'd4);
    wr(10'h014, 32'd4);
    wr(10'h100, 32'h0000_0024);
    @(negedge clk); irq_src[1] = 1'b1; irq_src[4] = 1'b1;
    edge_wait(2);
    peek(10'h080, d); check("t2_pending", d, 32'h24);
    rd(10'h204, d); check("t2_claim_tie", d, 32'd2);
    irq_src[1] = 1'b0;
    wr(10'h204, 32'd2);
    @(negedge clk); irq_src[1] = 1'b1;
    edge_wait(2);
    wr(10'h014, 32'd6);
    rd(10'h204, d); check("t2_claim_prio", d, 32'd5);
    irq_src[4] = 1'b0; irq_src[1] = 1'b0;
    wr(10'h204, 32'd5);
    rd(10'h204, d); check("t2_claim_rest", d, 32'd2);
    wr(10'h204, 32'd2);

    // 3: threshold gating (priority equal to threshold is blocked)
    wr(10'h004, 32'd3);
    wr(10'h100, 32'h0000_0002);
    wr(10'h200, 32'd3);
    @(negedge clk); irq_src[0] = 1'b1;
    edge_wait(3); check("t3_irq_blocked", {31'd0, irq_out}, 32'd0);
    rd(10'h204, d); check("t3_claim_zero", d, 32'd0);
    peek(10'h080, d); check("t3_still_pend", d, 32'h2);
    wr(10'h200, 32'd2);
    peek(10'h200, d); check("t3_thr_read", d, 32'd2);
    edge_wait(1); check("t3_irq_open", {31'd0, irq_out}, 32'd1);
    rd(10'h204, d); check("t3_claim", d, 32'd1);
    irq_src[0] = 1'b0;
    wr(10'h204, 32'd1);
    wr(10'h200, 32'd0);

    // 4: held source does not re-pend until completed
    wr(10'h010, 32'd5);
    wr(10'h100, 32'h0000_0010);
    @(negedge clk); irq_src[3] = 1'b1;
    edge_wait(2);
    rd(10'h204, d); check("t4_claim", d, 32'd4);
    edge_wait(3);
    peek(10'h080, d); check("t4_no_repend", d, 32'h0);
    check("t4_irq_low", {31'd0, irq_out}, 32'd0);
    wr(10'h204, 32'd4);
    peek(10'h080, d); check("t4_pend_at_cpl", d, 32'h0);
    edge_wait(1);
    peek(10'h080, d); check("t4_repend", d, 32'h10);
    check("t4_irq_not_yet", {31'd0, irq_out}, 32'd0);
    edge_wait(1); check("t4_irq_high", {31'd0, irq_out}, 32'd1);
    rd(10'h204, d); check("t4_claim2", d, 32'd4);

    // 5: ignored completes and unmapped / out-of-range reads
    wr(10'h204, 32'd0);
    wr(10'h204, 32'd7);
    wr(10'h204, 32'd31);
    edge_wait(2);
    peek(10'h080, d); check("t5_no_repend", d, 32'h0);
    check("t5_irq_low", {31'd0, irq_out}, 32'd0);
    peek(10'h3FC, d); check("t5_unmapped", d, 32'h0);
    peek(10'h000, d); check("t5_id0_slot", d, 32'h0);
    peek(10'h044, d); check("t5_id17_slot", d, 32'h0);
    peek(10'h010, d); check("t5_prio4_read", d, 32'd5);
    irq_src[3] = 1'b0;
    wr(10'h204, 32'd4);

    // 6: asynchronous reset mid-service
    wr(10'h018, 32'd7);
    wr(10'h100, 32'h0000_0050);
    @(negedge clk); irq_src[3] = 1'b1; irq_src[5] = 1'b1;
    edge_wait(2);
    rd(10'h204, d); check("t6_claim", d, 32'd6);
    edge_wait(1); check("t6_irq_pre", {31'd0, irq_out}, 32'd1);
    irq_src[3] = 1'b0;
    #2 reset = 1'b1;
    #1 check("t6_rst_irq", {31'd0, irq_out}, 32'd0);
    peek(10'h080, d); check("t6_rst_pending", d, 32'h0);
    peek(10'h100, d); check("t6_rst_enable", d, 32'h0);
    peek(10'h018, d); check("t6_rst_prio6", d, 32'h0);
    @(negedge clk); reset = 1'b0;
    edge_wait(1);
    peek(10'h080, d); check("t6_pend6", d, 32'h40);
    edge_wait(1); check("t6_irq_dis", {31'd0, irq_out}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
